// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_INCR      = 32'd4;
    localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_fetch_buffer.sv
// Prefetch FIFO holding {pc+4, instruction} pairs; flush clears it in one cycle.
module if_fetch_unit_fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    // Qualify push/pop against occupancy so the FIFO can never over- or underflow.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = push && (count_r != FULL_COUNT);
            pop_s  = pop && (count_r != {CNT_W{1'b0}});
        end
    end

    // Storage, pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, variable-latency memory handshake and
// prefetch buffer feeding the IF/ID register, with branch redirect and freeze.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int BUF_W = ADDR_W + 32;
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    fetch_state_t      state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic              imem_req_r;
    logic [ADDR_W-1:0] imem_addr_r;

    logic [CNT_W-1:0]  count_s;
    logic [BUF_W-1:0]  head_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic [ADDR_W-1:0] branch_target_s;
    logic              buf_valid_s;
    logic              push_s;
    logic              pop_s;

    // Datapath helpers: sequential PC, aligned redirect target, buffer push/pop.
    always_comb begin
        next_pc_s       = fetch_pc_r + ADDR_W'(PC_INCR);
        branch_target_s = branch_addr & ALIGN_MASK;
        buf_valid_s     = (count_s != {CNT_W{1'b0}});
        push_s          = (state_r == BUSY) && imem_ack && !branch_taken;
        pop_s           = buf_valid_s && !freeze && !branch_taken;
    end

    if_fetch_unit_fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (BUF_W)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (branch_taken),
        .push_data ({next_pc_s, imem_rdata}),
        .count     (count_s),
        .head      (head_s)
    );

    // Fetch FSM; the request address stays frozen while a request is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            fetch_pc_r  <= RESET_PC;
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (branch_taken) begin
                        fetch_pc_r <= branch_target_s;
                    end else if (count_s < FULL_COUNT) begin
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= fetch_pc_r & ALIGN_MASK;
                        state_r     <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (imem_ack) begin
                        imem_req_r <= 1'b0;
                        state_r    <= IDLE;
                        fetch_pc_r <= branch_taken ? branch_target_s : next_pc_s;
                    end else if (branch_taken) begin
                        fetch_pc_r <= branch_target_s;
                        state_r    <= DISCARD;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                DISCARD: begin
                    // The wrong-path word still has to be absorbed before a new request.
                    if (branch_taken) begin
                        fetch_pc_r <= branch_target_s;
                    end
                    if (imem_ack) begin
                        imem_req_r <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    imem_req_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // Head-of-buffer presentation; an empty buffer shows a zero bubble.
    always_comb begin
        if_valid = buf_valid_s;
        if_pc    = {ADDR_W{1'b0}};
        if_instr = INSTR_BUBBLE;
        if (buf_valid_s) begin
            if_pc    = head_s[BUF_W-1:32];
            if_instr = head_s[31:0];
        end else begin
            if_pc    = {ADDR_W{1'b0}};
            if_instr = INSTR_BUBBLE;
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table for streaming/freeze plus
// hand-written sequences for redirects, reset mid-request and PC wrap.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;

    logic        imem_req0, imem_ack0, if_valid0;
    logic [31:0] imem_addr0, imem_rdata0, if_pc0, if_instr0;
    logic        imem_req1, imem_ack1, if_valid1;
    logic [31:0] imem_addr1, imem_rdata1, if_pc1, if_instr1;

    bit auto0, auto1;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.DEPTH(2), .ADDR_W(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req0), .imem_addr(imem_addr0),
        .imem_ack(imem_ack0), .imem_rdata(imem_rdata0), .if_valid(if_valid0),
        .if_pc(if_pc0), .if_instr(if_instr0)
    );

    if_fetch_unit #(.DEPTH(2), .ADDR_W(32), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req1), .imem_addr(imem_addr1),
        .imem_ack(imem_ack1), .imem_rdata(imem_rdata1), .if_valid(if_valid1),
        .if_pc(if_pc1), .if_instr(if_instr1)
    );

    typedef struct {
        bit          do_reset;
        bit          freeze;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [19];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_dut(input int d, input string tag, input logic e_req,
                             input logic [31:0] e_addr, input logic e_valid,
                             input logic [31:0] e_pc);
        logic        a_req, a_valid;
        logic [31:0] a_addr, a_pc, a_instr, e_instr;
        if (d == 0) begin
            a_req = imem_req0; a_addr = imem_addr0; a_valid = if_valid0;
            a_pc = if_pc0; a_instr = if_instr0;
        end else begin
            a_req = imem_req1; a_addr = imem_addr1; a_valid = if_valid1;
            a_pc = if_pc1; a_instr = if_instr1;
        end
        e_instr = e_valid ? mem_word(e_pc - 32'd4) : 32'h0;
        chk({tag, ".req"},   {31'b0, a_req},   {31'b0, e_req});
        chk({tag, ".addr"},  a_addr,           e_addr);
        chk({tag, ".valid"}, {31'b0, a_valid}, {31'b0, e_valid});
        chk({tag, ".pc"},    a_pc,             e_pc);
        chk({tag, ".instr"}, a_instr,          e_instr);
    endtask

    // One clock: sample point is 1ns after the edge; zero-wait memory model.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_ack0   = auto0 & imem_req0;
        imem_rdata0 = mem_word(imem_addr0);
        imem_ack1   = auto1 & imem_req1;
        imem_rdata1 = mem_word(imem_addr1);
    endtask

    task automatic do_reset();
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack0 = 1'b0; imem_ack1 = 1'b0; auto0 = 1'b1; auto1 = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        // Streaming, no freeze: one instruction every two cycles.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h04, 1'b1, 32'h08};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0C};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0C, 1'b1, 32'h10};
        // Freeze for six cycles after the first valid: buffer fills, requests stop.
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h04};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'h04, 1'b1, 32'h04};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h04, 1'b1, 32'h04};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h04, 1'b1, 32'h08};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h00};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h08, 1'b1, 32'h0C};

        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack0 = 1'b0; imem_ack1 = 1'b0; imem_rdata0 = 32'h0; imem_rdata1 = 32'h0;
        auto0 = 1'b1; auto1 = 1'b1;
        #2 rst = 1'b0;
        #1;
        check_dut(0, "reset0", 1'b0, 32'h0000_0000, 1'b0, 32'h0);
        check_dut(1, "reset1", 1'b0, 32'hFFFF_FFF8, 1'b0, 32'h0);

        for (int i = 0; i < 19; i++) begin
            if (vecs[i].do_reset) do_reset();
            tick();
            check_dut(0, $sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                      vecs[i].valid, vecs[i].pc);
            freeze = vecs[i].freeze;
        end

        // Redirect while BUSY without ack: wrong-path word dropped, target aligned.
        do_reset();
        auto0 = 1'b0;
        tick(); check_dut(0, "t3.c1", 1'b1, 32'h0, 1'b0, 32'h0);
        branch_taken = 1'b1; branch_addr = 32'h0000_0103;
        tick(); branch_taken = 1'b0;
        check_dut(0, "t3.c2", 1'b1, 32'h0, 1'b0, 32'h0);
        imem_ack0 = 1'b1;
        tick(); check_dut(0, "t3.c3", 1'b0, 32'h0, 1'b0, 32'h0);
        tick(); check_dut(0, "t3.c4", 1'b1, 32'h100, 1'b0, 32'h0);
        imem_ack0 = 1'b1;
        tick(); check_dut(0, "t3.c5", 1'b0, 32'h100, 1'b1, 32'h104);

        // Redirect coinciding with ack, buffer holding an entry: data dropped, flushed.
        do_reset();
        tick(); check_dut(0, "t4.c1", 1'b1, 32'h0, 1'b0, 32'h0);
        freeze = 1'b1;
        tick(); check_dut(0, "t4.c2", 1'b0, 32'h0, 1'b1, 32'h4);
        tick(); check_dut(0, "t4.c3", 1'b1, 32'h4, 1'b1, 32'h4);
        branch_taken = 1'b1; branch_addr = 32'h0000_0040;
        tick(); branch_taken = 1'b0; freeze = 1'b0;
        check_dut(0, "t4.c4", 1'b0, 32'h4, 1'b0, 32'h0);
        tick(); check_dut(0, "t4.c5", 1'b1, 32'h40, 1'b0, 32'h0);
        tick(); check_dut(0, "t4.c6", 1'b0, 32'h40, 1'b1, 32'h44);

        // Reset pulse during an outstanding request; a stray ack must be ignored.
        do_reset();
        tick();
        tick();
        auto0 = 1'b0;
        tick(); check_dut(0, "t5.c3", 1'b1, 32'h4, 1'b0, 32'h0);
        tick(); check_dut(0, "t5.c4", 1'b1, 32'h4, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        check_dut(0, "t5.rst", 1'b0, 32'h0, 1'b0, 32'h0);
        imem_ack0 = 1'b1;
        tick();
        imem_ack0 = 1'b1;
        rst = 1'b1;
        tick(); check_dut(0, "t5.r1", 1'b1, 32'h0, 1'b0, 32'h0);
        tick(); check_dut(0, "t5.r2", 1'b1, 32'h0, 1'b0, 32'h0);
        auto0 = 1'b1;

        // PC wrap on the instance reset near the top of the address space.
        do_reset();
        tick(); check_dut(1, "t6.c1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        tick(); check_dut(1, "t6.c2", 1'b0, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFC);
        tick(); check_dut(1, "t6.c3", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick(); check_dut(1, "t6.c4", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000);
        tick(); check_dut(1, "t6.c5", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        tick(); check_dut(1, "t6.c6", 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
